dmem_responder: RTL and testbench

//   Responder end of the 256-bit line interface the data cache drives: off-chip data memory model/controller.

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_line_array.sv | 18 +
 rtl/dmem_responder.sv | 76 +++++++
 tb/tb_dmem_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and FSM state encoding for the data-memory responder
package dmem_pkg;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 32;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } dmem_state_e;
endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: line storage with a synchronous write port and a combinational read port; contents survive reset
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [LINE_W-1:0]     i_wdata,
  output logic [LINE_W-1:0]     o_rdata
);
  logic [LINE_W-1:0] r_mem [2**DEPTH_LOG2];
  // commit a line write on the clock edge
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_idx] <= i_wdata;
  assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding 256-bit line memory with fixed access latency; define DMEM_OOR_ERR_EN to flag out-of-range addresses via err_o
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic [LINE_W-1:0] data_o,
  output logic              ack_o
`ifdef DMEM_OOR_ERR_EN
  ,
  output logic              err_o
`endif
);
  localparam int CNT_W = $clog2(LATENCY + 1);
  dmem_state_e           r_state, w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_write, r_oor;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [LINE_W-1:0]     r_data, w_rdata;
  logic                  w_fire, w_we, w_oor_in, w_unused;
`ifdef DMEM_OOR_ERR_EN
  assign w_oor_in = |addr_i[ADDR_W-1:DEPTH_LOG2+OFFSET_W];
  assign err_o    = ack_o & r_oor;
`else
  assign w_oor_in = 1'b0;
`endif
  assign w_unused = ^{addr_i[ADDR_W-1:DEPTH_LOG2+OFFSET_W], addr_i[OFFSET_W-1:0]};
  assign w_fire   = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_we     = w_fire && r_write && !r_oor;
  // state register
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_next;
  // next-state: requests are only sampled in IDLE, ACK always returns to IDLE
  always_comb
    w_next = (r_state == ST_IDLE) ? (enable_i ? ST_BUSY : ST_IDLE) :
             (r_state == ST_BUSY) ? ((r_cnt == '0) ? ST_ACK : ST_BUSY) : ST_IDLE;
  // outputs: ack is exactly the single ACK-state cycle
  always_comb
    ack_o = (r_state == ST_ACK);
  // request capture and latency countdown
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_oor   <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
    end else if (r_state == ST_IDLE && enable_i) begin
      r_cnt   <= CNT_W'(LATENCY - 1);
      r_write <= write_i;
      r_oor   <= w_oor_in;
      r_idx   <= addr_i[DEPTH_LOG2+OFFSET_W-1:OFFSET_W];
      r_data  <= data_i;
    end else if (r_state == ST_BUSY && r_cnt != '0) begin
      r_cnt   <= r_cnt - 1'b1;
    end
  // read data updates only on read completion and holds otherwise
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i)                 data_o <= '0;
    else if (w_fire && !r_write) data_o <= r_oor ? '0 : w_rdata;
  dmem_line_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .i_clk   (clk_i),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (r_data),
    .o_rdata (w_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench against a line-array reference model
module tb_dmem_responder;
  localparam int L = 10;
`ifdef DMEM_OOR_ERR_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0;
  logic [255:0] wdata = '0, rdata;
  logic ack, err;
  logic e1 = 1'b0, w1 = 1'b0, ack1, err1;
  logic [31:0] a1 = '0;
  logic [255:0] d1 = '0, do1;
  int vec_cnt = 0, err_cnt = 0;
  logic [255:0] m_mem [512];
  logic [255:0] last_rd = '0;
  bit cur_w;
  logic [31:0] cur_a;
  logic [255:0] cur_d;
  logic [8:0] pool [8] = '{9'd0, 9'd1, 9'd2, 9'd4, 9'd37, 9'd128, 9'd300, 9'd511};

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(L), .DEPTH_LOG2(9)) dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en), .write_i(wr), .addr_i(addr),
    .data_i(wdata), .data_o(rdata), .ack_o(ack)
`ifdef DMEM_OOR_ERR_EN
    , .err_o(err)
`endif
  );
  dmem_responder #(.LATENCY(1), .DEPTH_LOG2(9)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .enable_i(e1), .write_i(w1), .addr_i(a1),
    .data_i(d1), .data_o(do1), .ack_o(ack1)
`ifdef DMEM_OOR_ERR_EN
    , .err_o(err1)
`endif
  );
`ifndef DMEM_OOR_ERR_EN
  assign err = 1'b0;
  assign err1 = 1'b0;
`endif

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [255:0] d);
    en = 1'b1; wr = w; addr = a; wdata = d;
    cur_w = w; cur_a = a; cur_d = d;
  endtask

  // Counts falling edges from the drive point until ack; n==1 is the first edge after the drive.
  task automatic wait_ack(input string tag, input int exp_n, input bit glitch);
    int n = 0;
    logic [8:0] idx = cur_a[13:5];
    bit oor = OOR_EN && (cur_a[31:14] != 18'd0);
    do begin
      @(negedge clk);
      n++;
      if (glitch && n == 2) begin
        en = 1'($urandom_range(0, 1)); wr = ~wr; addr = $urandom;
        wdata = {8{$urandom}};
      end
    end while (!ack && n < 60);
    check({tag, "_lat"}, 256'(n), 256'(exp_n));
    if (!ack) return;
    check({tag, "_err"}, 256'(err), 256'(oor));
    if (cur_w) begin
      if (!oor) m_mem[idx] = cur_d;
      check({tag, "_wr_hold"}, rdata, last_rd);
    end else begin
      last_rd = oor ? 256'd0 : m_mem[idx];
      check({tag, "_rd"}, rdata, last_rd);
    end
  endtask

  task automatic drop(input string tag);
    en = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 256'(ack), 256'd0);
    check({tag, "_err0"}, 256'(err), 256'd0);
  endtask

  initial begin
    logic [255:0] pat_a, pat_b, q;
    bit b2b;
    int n;
    repeat (3) @(negedge clk);
    check("rst_ack", 256'(ack), 256'd0);
    check("rst_data", rdata, 256'd0);
    check("rst_err", 256'(err), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 32'h40, {8{32'hDEADBEEF}});
    wait_ack("wr40", L + 1, 1'b0);
    drop("wr40");
    issue(1'b0, 32'h40, '0);
    wait_ack("rd40", L + 1, 1'b0);
    drop("rd40");
    repeat (3) @(negedge clk);
    check("rd40_held", rdata, {8{32'hDEADBEEF}});
    issue(1'b1, 32'h400, {8{32'h0BADF00D}});
    wait_ack("wb400", L + 1, 1'b0);
    issue(1'b0, 32'h40, '0);
    wait_ack("refill40", L + 2, 1'b0);
    drop("refill40");
    issue(1'b0, 32'h400, '0);
    wait_ack("glitch400", L + 1, 1'b1);
    drop("glitch400");
    issue(1'b1, 32'h0, {8{32'h13579BDF}});
    wait_ack("wr0", L + 1, 1'b0);
    drop("wr0");
    issue(1'b0, 32'hFFFF0000, '0);
    wait_ack("rd_hi", L + 1, 1'b0);
    drop("rd_hi");
    foreach (pool[i]) begin
      issue(1'b1, {18'd0, pool[i], 5'd0}, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      wait_ack("fill", L + 1, 1'b0);
      drop("fill");
    end
    b2b = 1'b0;
    for (int k = 0; k < 40; k++) begin
      issue(1'($urandom_range(0, 1)),
            {($urandom_range(0, 3) == 0) ? 18'($urandom | 1) : 18'd0, pool[$urandom_range(0, 7)], 5'($urandom)},
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      wait_ack("rand", b2b ? L + 2 : L + 1, 1'($urandom_range(0, 3) == 0));
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) drop("rand");
    end
    if (b2b) drop("rand_end");
    pat_a = {8{32'hA5A5_0080}};
    pat_b = {8{32'h5A5A_FFFF}};
    issue(1'b1, 32'h80, pat_a);
    wait_ack("wr80", L + 1, 1'b0);
    drop("wr80");
    issue(1'b1, 32'h80, pat_b);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ack", 256'(ack), 256'd0);
    check("midrst_data", rdata, 256'd0);
    en = 1'b0;
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h80, '0);
    wait_ack("rd80_after_rst", L + 1, 1'b0);
    check("rd80_prior", rdata, pat_a);
    drop("rd80_after_rst");
    q = {8{32'hC0FFEE11}};
    for (int k = 0; k < 2; k++) begin
      e1 = 1'b1; w1 = (k == 0); a1 = 32'h60; d1 = (k == 0) ? q : '0;
      n = 0;
      do begin @(negedge clk); n++; end while (!ack1 && n < 20);
      check("l1_lat", 256'(n), 256'd2);
      if (k == 1) check("l1_rd", do1, q);
      e1 = 1'b0;
      @(negedge clk);
      check("l1_pulse", 256'(ack1), 256'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
